// File: rtl/ser.sv
// Serial-in/parallel-out shift register; SER_MSB_IN_EN reverses direction (newest bit in out[WIDTH-1]).
// Latency: a bit sampled at edge k is on the entry end of out after edge k, at the far end after edge k+WIDTH-1.
// Backpressure: none; every rising clk edge shifts, no enable or handshake.
module ser #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             in,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out
);

    // Async clear must win over any edge in progress, so reset is in the sensitivity list.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= RESET_VAL;
        end else begin
`ifdef SER_MSB_IN_EN
            out <= {in, out[WIDTH-1:1]};
`else
            out <= {out[WIDTH-2:0], in};
`endif
        end
    end

endmodule

// File: tb/tb_ser.sv
// Randomized and directed checks of ser against a bit-history reference model.
module tb_ser;
    localparam int         W  = 4;
    localparam logic [W-1:0] RV = '0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in = 1'b0;
    logic [W-1:0] out;

    int tests = 0;
    int fails = 0;
    bit hist[$];

    ser #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .in   (in),
        .clk  (clk),
        .reset(reset),
        .out  (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Expected word: bits sampled since reset, newest at the entry end, reset value filling the rest.
    function automatic logic [W-1:0] model();
        logic [W-1:0] r;
        int n;
        n = hist.size();
        r = '0;
        for (int i = 0; i < W; i++) begin
`ifdef SER_MSB_IN_EN
            r[W-1-i] = (i < n) ? hist[n-1-i] : RV[W-1-(i-n)];
`else
            r[i] = (i < n) ? hist[n-1-i] : RV[i-n];
`endif
        end
        return r;
    endfunction

    task automatic step(input bit b, input string tag);
        in = b;
        @(posedge clk);
        hist.push_back(b);
        if (hist.size() > W) void'(hist.pop_front());
        #1;
        check(tag, out, model());
    endtask

    // Called at posedge+1; asserts reset mid-period and releases it at the next negedge.
    task automatic reset_pulse(input string tag);
        #2 reset = 1'b0;
        #1 check(tag, out, RV);
        hist.delete();
        @(negedge clk);
        check({tag, "_held"}, out, RV);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] tmp;
        // Reset takes effect before any clock edge
        #2 reset = 1'b0;
        #1 check("reset_async", out, RV);
        in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("reset_hold", out, RV);
        end
        @(negedge clk);
        reset = 1'b1;
        hist.delete();

`ifdef SER_MSB_IN_EN
        step(1'b1, "msb_1");
        check("msb_c1", out, 4'b1000);
        step(1'b0, "msb_2");
        check("msb_c2", out, 4'b0100);
        step(1'b0, "msb_3");
        check("msb_c3", out, 4'b0010);
        step(1'b0, "msb_4");
        check("msb_c4", out, 4'b0001);
        step(1'b0, "msb_5");
        check("msb_c5", out, 4'b0000);
`else
        step(1'b1, "fill_1");
        check("fill_c1", out, 4'b0001);
        step(1'b1, "fill_2");
        check("fill_c2", out, 4'b0011);
        step(1'b1, "fill_3");
        check("fill_c3", out, 4'b0111);
        step(1'b1, "fill_4");
        check("fill_c4", out, 4'b1111);
        step(1'b1, "fill_5");
        check("fill_c5", out, 4'b1111);
        step(1'b0, "drain_1");
        check("drain_c1", out, 4'b1110);
        step(1'b0, "drain_2");
        check("drain_c2", out, 4'b1100);
        step(1'b0, "drain_3");
        check("drain_c3", out, 4'b1000);
        step(1'b0, "drain_4");
        check("drain_c4", out, 4'b0000);
`endif

        // Serial 1,0,1,1 after reset
        @(posedge clk);
        #1 reset_pulse("rst_pat");
        step(1'b1, "pat_1");
        step(1'b0, "pat_2");
        step(1'b1, "pat_3");
        step(1'b1, "pat_4");
`ifndef SER_MSB_IN_EN
        check("pat_word", out, 4'b1011);
`endif

        // Mid-period reset from a partly filled register
        @(posedge clk);
        #1 reset_pulse("rst_pre");
        step(1'b1, "mid_1");
        step(1'b1, "mid_2");
        step(1'b1, "mid_3");
        tmp = model();
        check("mid_before", out, tmp);
        reset_pulse("rst_mid");
        step(1'b1, "mid_after");
`ifndef SER_MSB_IN_EN
        check("mid_after_c", out, 4'b0001);
`endif

        // Random serial stream with occasional async resets
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 24) == 0) reset_pulse("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
